// File: rtl/mem_req_bridge_if.sv
// mem_req_bridge_if: upstream request, SRAM-like data bus and response
// signals of the data-side memory request bridge.
interface mem_req_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [3:0]  req_wen_4b;
    logic [31:0] req_wdata;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        resp_valid;
    logic        resp_wr;
    logic [31:0] resp_rdata;

    modport master (
        input  req_valid, req_addr, req_size, req_wen_4b, req_wdata,
        input  flush, data_addr_ok, data_data_ok, data_rdata,
        output req_ready, data_req, data_wr, data_size, data_addr,
        output data_wstrb, data_wdata, resp_valid, resp_wr, resp_rdata
    );

    modport slave (
        output req_valid, req_addr, req_size, req_wen_4b, req_wdata,
        output flush, data_addr_ok, data_data_ok, data_rdata,
        input  req_ready, data_req, data_wr, data_size, data_addr,
        input  data_wstrb, data_wdata, resp_valid, resp_wr, resp_rdata
    );
endinterface

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: captures one load/store, holds it on the data bus until
// address accept, tracks outstanding beats and drops flushed responses.
module mem_req_bridge #(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic            clk,
    input logic            resetn,
    mem_req_bridge_if.master bus
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] outstanding;
    logic [2:0] cancel_cnt;
    logic [2:0] wptr;
    logic [2:0] rptr;
    logic [7:0] wr_flags;
    logic       accept;
    logic       push;
    logic       pop;
    logic       deliver;
    logic [2:0] cancel_new;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == MAX_C - 3'd1) ? 3'd0 : p + 3'd1;
    endfunction

    assign bus.req_ready = (state == IDLE) && (outstanding < MAX_C)
                           && !bus.flush;
    assign bus.data_req  = (state == REQ);
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = (state == REQ) && bus.data_addr_ok;
    // A data_ok with nothing outstanding is a bus protocol error; ignore it.
    assign pop           = bus.data_data_ok && (outstanding != 3'd0);
    assign deliver       = pop && (cancel_cnt == 3'd0) && !bus.flush;
    // pop implies outstanding >= 1, and REQ implies outstanding < MAX,
    // so this neither underflows nor overflows.
    assign cancel_new    = outstanding + {2'b00, state == REQ}
                           - {2'b00, pop};

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state: one capture per handshake, released on address accept
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ:  if (bus.data_addr_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request; held stable for the whole REQ phase
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.data_wr    <= 1'b0;
            bus.data_size  <= 2'd0;
            bus.data_addr  <= 32'd0;
            bus.data_wstrb <= 4'd0;
            bus.data_wdata <= 32'd0;
        end else if (accept) begin
            bus.data_wr    <= |bus.req_wen_4b;
            bus.data_size  <= bus.req_size;
            bus.data_addr  <= bus.req_addr;
            bus.data_wstrb <= bus.req_wen_4b;
            bus.data_wdata <= bus.req_wdata;
        end
    end

    // Outstanding count and in-order write-flag FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= 3'd0;
            wptr        <= 3'd0;
            rptr        <= 3'd0;
            wr_flags    <= 8'd0;
        end else begin
            outstanding <= outstanding + {2'b00, push} - {2'b00, pop};
            if (push) begin
                wr_flags[wptr] <= bus.data_wr;
                wptr           <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
        end
    end

    // Cancel count: a flush reloads it with everything still in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                              cancel_cnt <= 3'd0;
        else if (bus.flush)                       cancel_cnt <= cancel_new;
        else if (pop && cancel_cnt != 3'd0)       cancel_cnt <= cancel_cnt - 3'd1;
    end

    // Response pulse; payload held until the next delivered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.resp_valid <= 1'b0;
            bus.resp_wr    <= 1'b0;
            bus.resp_rdata <= 32'd0;
        end else begin
            bus.resp_valid <= deliver;
            if (deliver) begin
                bus.resp_wr    <= wr_flags[rptr];
                bus.resp_rdata <= bus.data_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_bridge.sv
// tb_mem_req_bridge: directed tests for the data-side request bridge.
// Inputs change and outputs are sampled around the falling edge.
module tb_mem_req_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mem_req_bridge_if bus();

    mem_req_bridge #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic put_req(input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] wen, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_size   = sz;
        bus.req_wen_4b = wen;
        bus.req_wdata  = wd;
    endtask

    task automatic addr_phase();
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_addr = 0; bus.req_size = 0;
        bus.req_wen_4b = 0; bus.req_wdata = 0; bus.flush = 0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr,
             bus.data_wstrb, bus.data_wdata} !== 72'd0)
            $display("FAIL reset_bus: got %h want 0", bus.data_addr);
        else pass_cnt++;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_wr, bus.resp_rdata} !== 34'd0)
            $display("FAIL reset_resp: got %h want 0", bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total_cnt++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_load();
        put_req(32'h1000_0004, 2'd2, 4'b0000, 32'h5555_5555);
        #1;
        total_cnt++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL load_ready: got %b want 1", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = 0;
        bus.data_addr_ok = 1;
        #1;
        total_cnt++;
        if ({bus.data_req, bus.data_wr, bus.data_wstrb, bus.data_size}
            !== 8'b1_0_0000_10)
            $display("FAIL load_ctrl: got %b%b%b%b want 10000010",
                     bus.data_req, bus.data_wr, bus.data_wstrb,
                     bus.data_size);
        else pass_cnt++;
        total_cnt++;
        if (bus.data_addr !== 32'h1000_0004)
            $display("FAIL load_addr: got %h want 10000004",
                     bus.data_addr);
        else pass_cnt++;
        @(negedge clk);
        bus.data_addr_ok = 0;
        @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL load_early: got %b want 0", bus.resp_valid);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_wr, bus.resp_rdata}
            !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL load_resp: got %b%b %h want 10 deadbeef",
                     bus.resp_valid, bus.resp_wr, bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_rdata} !== {1'b0, 32'hDEAD_BEEF})
            $display("FAIL load_pulse: got %b %h want 0 deadbeef",
                     bus.resp_valid, bus.resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_store_byte();
        put_req(32'h2000_0002, 2'd0, 4'b0100, 32'h00AB_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid  = 1;
            bus.req_addr   = 32'hFFFF_FFF0;
            bus.req_wen_4b = 4'b1111;
            bus.req_wdata  = 32'h1234_5678;
            bus.data_addr_ok = (i == 3);
            #1;
            total_cnt++;
            if ({bus.data_req, bus.data_wr, bus.req_ready,
                 bus.data_wstrb, bus.data_addr, bus.data_wdata}
                !== {3'b110, 4'b0100, 32'h2000_0002, 32'h00AB_0000})
                $display("FAIL store_hold%0d: got %b%b%b %h %h %h",
                         i, bus.data_req, bus.data_wr, bus.req_ready,
                         bus.data_wstrb, bus.data_addr, bus.data_wdata);
            else pass_cnt++;
        end
        @(negedge clk);
        bus.req_valid = 0;
        bus.data_addr_ok = 0;
        #1;
        total_cnt++;
        if ({bus.data_req, bus.req_ready} !== 2'b01)
            $display("FAIL store_release: got %b%b want 01",
                     bus.data_req, bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_wr} !== 2'b11)
            $display("FAIL store_resp: got %b%b want 11",
                     bus.resp_valid, bus.resp_wr);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        put_req(32'h0000_0100, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        put_req(32'h0000_0104, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        put_req(32'h0000_0108, 2'd2, 4'b0000, 32'd0);
        #1;
        total_cnt++;
        if (bus.req_ready !== 1'b0)
            $display("FAIL bp_full: got %b want 0", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hA1;
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.data_req} !== 2'b00)
            $display("FAIL bp_stall: got %b%b want 00",
                     bus.req_ready, bus.data_req);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.req_ready, bus.resp_rdata}
            !== {2'b11, 32'hA1})
            $display("FAIL bp_first: got %b%b %h want 11 a1",
                     bus.resp_valid, bus.req_ready, bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = 0;
        bus.data_addr_ok = 1;
        #1;
        total_cnt++;
        if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h108})
            $display("FAIL bp_third: got %b %h want 1 108",
                     bus.data_req, bus.data_addr);
        else pass_cnt++;
        @(negedge clk);
        bus.data_addr_ok = 0;
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hA2;
        @(negedge clk);
        bus.data_rdata = 32'hA3;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, 32'hA2})
            $display("FAIL bp_second: got %b %h want 1 a2",
                     bus.resp_valid, bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, 32'hA3})
            $display("FAIL bp_last: got %b %h want 1 a3",
                     bus.resp_valid, bus.resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        put_req(32'h0000_0200, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        put_req(32'h0000_0204, 2'd2, 4'b0011, 32'h0000_BEEF);
        @(negedge clk);
        bus.flush = 1;
        bus.req_addr = 32'h0000_0F00;
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.data_req} !== 2'b01)
            $display("FAIL flush_cycle: got %b%b want 01",
                     bus.req_ready, bus.data_req);
        else pass_cnt++;
        @(negedge clk);
        bus.flush = 0;
        bus.req_valid = 0;
        bus.data_addr_ok = 1;
        #1;
        total_cnt++;
        if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h204})
            $display("FAIL flush_hold: got %b %h want 1 204",
                     bus.data_req, bus.data_addr);
        else pass_cnt++;
        @(negedge clk);
        bus.data_addr_ok = 0;
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hBAD1;
        @(negedge clk);
        bus.data_rdata = 32'hBAD2;
        #1;
        total_cnt++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL flush_drop1: got %b want 0", bus.resp_valid);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL flush_drop2: got %b want 0", bus.resp_valid);
        else pass_cnt++;
        put_req(32'h0000_0300, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        bus.data_data_ok = 1;
        bus.data_rdata = 32'h600D;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, 32'h600D})
            $display("FAIL flush_after: got %b %h want 1 600d",
                     bus.resp_valid, bus.resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        put_req(32'h0000_0400, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        put_req(32'h0000_0404, 2'd2, 4'b1111, 32'hCAFE_CAFE);
        @(negedge clk);
        bus.req_valid = 0;
        bus.data_addr_ok = 1;
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hC1;
        @(negedge clk);
        bus.data_addr_ok = 0;
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_wr, bus.req_ready, bus.resp_rdata}
            !== {3'b101, 32'hC1})
            $display("FAIL sim_both: got %b%b%b %h want 101 c1",
                     bus.resp_valid, bus.resp_wr, bus.req_ready,
                     bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hC2;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_wr, bus.resp_rdata}
            !== {2'b11, 32'hC2})
            $display("FAIL sim_order: got %b%b %h want 11 c2",
                     bus.resp_valid, bus.resp_wr, bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hEE;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.req_ready, bus.resp_rdata}
            !== {2'b01, 32'hC2})
            $display("FAIL sim_spurious: got %b%b %h want 01 c2",
                     bus.resp_valid, bus.req_ready, bus.resp_rdata);
        else pass_cnt++;
        put_req(32'h0000_0500, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        bus.flush = 1;
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hD0;
        @(negedge clk);
        bus.flush = 0;
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if (bus.resp_valid !== 1'b0)
            $display("FAIL sim_flush_drop: got %b want 0", bus.resp_valid);
        else pass_cnt++;
        put_req(32'h0000_0504, 2'd2, 4'b0000, 32'd0);
        addr_phase();
        bus.data_data_ok = 1;
        bus.data_rdata = 32'hD1;
        @(negedge clk);
        bus.data_data_ok = 0;
        #1;
        total_cnt++;
        if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, 32'hD1})
            $display("FAIL sim_flush_next: got %b %h want 1 d1",
                     bus.resp_valid, bus.resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        put_req(32'h0000_0600, 2'd1, 4'b0011, 32'h0000_7777);
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        total_cnt++;
        if (bus.data_req !== 1'b1)
            $display("FAIL rst_mid_pre: got %b want 1", bus.data_req);
        else pass_cnt++;
        resetn = 0;
        #1;
        total_cnt++;
        if ({bus.data_req, bus.data_wr, bus.data_addr, bus.data_wstrb,
             bus.data_wdata, bus.resp_valid, bus.resp_rdata} !== 103'd0)
            $display("FAIL rst_mid_zero: got %b %h %h want 0 0 0",
                     bus.data_req, bus.data_addr, bus.resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1;
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.data_req} !== 2'b10)
            $display("FAIL rst_mid_ready: got %b%b want 10",
                     bus.req_ready, bus.data_req);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_req_bridge.md
# mem_req_bridge

Data-side memory request bridge between the execute stage's store-enable/alignment logic and the external SRAM-like data bus. It captures one load/store per handshake, including the 4-bit byte write enable produced upstream. It holds the bus request stable until the address phase is accepted, and tracks outstanding transactions. It returns read data to the memory/writeback stage and discards responses belonging to flushed instructions.

## Interface
- MAX_OUTSTANDING, 2: maximum address-accepted transactions awaiting data_ok (1..7)
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  upstream has a memory request this cycle
- req_ready  out  1  bridge accepts request this cycle (combinational)
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word
- req_wen_4b  in  4  byte write enables; 4'b0000 means load
- req_wdata  in  32  lane-aligned store data
- flush  in  1  pipeline flush; cancel responses of all in-flight transactions
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  copy of captured req_size
- data_addr  out  32  captured address
- data_wstrb  out  4  captured req_wen_4b
- data_wdata  out  32  captured req_wdata
- data_addr_ok  in  1  address phase accepted (valid only while data_req=1)
- data_data_ok  in  1  data phase complete, one per accepted transaction, in order
- data_rdata  in  32  read data, valid with data_data_ok
- resp_valid  out  1  one-cycle response pulse to memory/writeback stage
- resp_wr  out  1  response belongs to a write
- resp_rdata  out  32  registered read data (don't-care for writes)

## Operation
- States: IDLE, REQ.
- outstanding counter: 3 bits. cancel_cnt counter: 3 bits. resp_wr_q: FIFO of MAX_OUTSTANDING write flags, indexed in order.
- req_ready = (state==IDLE) && (outstanding < MAX_OUTSTANDING) && !flush.
- IDLE: on req_valid && req_ready, capture addr/size/wdata/wen_4b and set data_wr = |req_wen_4b. Go to REQ.
- REQ: data_req=1. All data_* outputs are held stable. A request is never withdrawn, even across flush.
- REQ: on data_addr_ok, push data_wr into the write-flag FIFO, increment outstanding, and go to IDLE.
- data_data_ok:
  - Decrement outstanding and pop the write-flag FIFO.
  - If cancel_cnt==0 and flush==0: resp_valid=1 next cycle, with resp_wr = popped flag and resp_rdata = data_rdata.
  - Else the response is dropped. If flush==0, cancel_cnt decrements.
- addr_ok and data_ok in the same cycle: outstanding is unchanged. The FIFO does a simultaneous push and pop.
- data_data_ok with outstanding==0 is a protocol error. It is ignored: counter stays 0, no response.
- flush cycle:
  - cancel_cnt <= outstanding + (state==REQ) - data_data_ok, floored at 0. This supersedes any prior cancel_cnt, since outstanding already includes cancelled entries.
  - req_ready=0, so a req_valid in the flush cycle is not accepted.
- Writes issued before a flush still complete on the bus. Only their responses are suppressed.
- Counters never wrap: outstanding ≤ MAX_OUTSTANDING by construction, and cancel_cnt ≤ outstanding+1.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE; outstanding=0; cancel_cnt=0; FIFO empty.
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0.
  - resp_valid=0, resp_wr=0, resp_rdata=0.
- Reset mid-transaction drops all state. The bus side is assumed reset together.
- Accept at edge N → data_req=1 during cycle N+1.
- addr_ok in cycle N+1 → IDLE at N+2. req_ready may reassert in cycle N+2, so the peak issue rate is one request per 2 cycles.
- data_data_ok in cycle M → resp_valid high in cycle M+1 only.
- resp_rdata and resp_wr are held until the next response.

## Test plan
- Load:
  - Stimulus: addr=0x1000_0004, wen=0000, size=2; addr_ok on first data_req cycle; data_ok 2 cycles later with rdata=0xDEADBEEF.
  - Required: data_wr=0, data_wstrb=0, resp_valid one cycle with resp_rdata=0xDEADBEEF, resp_wr=0.
- Store byte:
  - Stimulus: wen=0100, wdata=0x00AB0000, addr=0x...02; addr_ok delayed 3 cycles.
  - Required: data_req, data_addr, data_wstrb=0100, data_wdata stable for all 4 cycles; req_ready=0 throughout; resp_wr=1 after data_ok.
- Backpressure:
  - Stimulus: 3 back-to-back loads; data_ok withheld.
  - Required: two addr_ok handshakes, then req_ready=0 with outstanding=2.
  - Then: after one data_ok, the third request issues.
- Flush:
  - Stimulus: flush asserted while outstanding=1 and state=REQ.
  - Required: cancel_cnt=2; next two data_ok produce no resp_valid.
  - Then: a load issued afterwards responds normally.
- Simultaneous events:
  - Case 1: addr_ok and data_ok in the same cycle → outstanding unchanged; response order preserved.
  - Case 2: flush and data_ok in the same cycle → that response dropped.
  - Case 3: spurious data_ok with outstanding=0 → ignored.
- Reset: resetn low mid-REQ → all outputs 0 immediately; req_ready=1 after release.
